// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
// Scans a 4x3 matrix keypad with one-hot row strobes, samples the column
// sense lines once per row, debounces whole frames and pushes one key code
// per accepted press into a small show-ahead FIFO read with valid/ready.
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-enqueue a held key
// every REPEAT_FRAMES frames; without it REPEAT_FRAMES is only range-checked.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int REPEAT_FRAMES  = 64
) (
    input  logic       clk,
    input  logic       init_n,
    output logic [3:0] row,
    input  logic [2:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       overflow
);

    localparam int DIV_W  = (SCAN_DIV > 32'sd1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 32'sd1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 32'sd1);

    localparam logic [DIV_W-1:0]  DIV_ZERO   = DIV_W'(32'd0);
    localparam logic [DIV_W-1:0]  DIV_ONE    = DIV_W'(32'd1);
    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(SCAN_DIV - 32'sd1);
    localparam logic [CNT_W-1:0]  CNT_ZERO   = CNT_W'(32'd0);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0]  DEB_TARGET = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [PTR_W-1:0]  PTR_ZERO   = PTR_W'(32'd0);
    localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(32'd1);
    localparam logic [FCNT_W-1:0] FCNT_ZERO  = FCNT_W'(32'd0);
    localparam logic [FCNT_W-1:0] FCNT_ONE   = FCNT_W'(32'd1);
    localparam logic [FCNT_W-1:0] FIFO_FULL  = FCNT_W'(FIFO_DEPTH);

    // Reject parameter sets the scan and FIFO logic cannot support
    if (SCAN_DIV < 32'sd1 || DEBOUNCE_SCANS < 32'sd1 || REPEAT_FRAMES < 32'sd1 ||
        FIFO_DEPTH < 32'sd2 || (FIFO_DEPTH & (FIFO_DEPTH - 32'sd1)) != 32'sd0) begin : g_bad_cfg
        $error("keypad_scan_ctrl: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_DEB_PRESS   = 2'd1,
        ST_HELD        = 2'd2,
        ST_DEB_RELEASE = 2'd3
    } scan_state_t;

    // Key position to code: rows 0..2 are 1..9, bottom row is '*', 0, '#'
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        if (r == 2'd3) begin
            case (c)
                2'd0:    code = 4'd10;
                2'd1:    code = 4'd0;
                default: code = 4'd11;
            endcase
        end else begin
            code = ({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1;
        end
        return code;
    endfunction

    logic [DIV_W-1:0]  div_r;
    logic [3:0]        row_r;
    logic [1:0]        row_idx_s;
    logic              sample_s;
    logic              frame_end_s;

    logic              row_hit_s;
    logic              row_multi_s;
    logic [1:0]        col_idx_s;
    logic [3:0]        row_code_s;

    logic              acc_hit_r;
    logic              acc_multi_r;
    logic [3:0]        acc_code_r;
    logic              merged_hit_s;
    logic              merged_multi_s;
    logic [3:0]        merged_code_s;
    logic              res_none_s;
    logic              res_key_s;

    scan_state_t       state_r, state_next_s;
    logic [CNT_W-1:0]  cnt_r, cnt_next_s;
    logic [3:0]        cand_r, cand_next_s;
    logic              push_req_r, push_next_s;
    logic [3:0]        push_code_r, push_code_next_s;

    logic [3:0]        mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r, wr_ptr_next_s;
    logic [PTR_W-1:0]  rd_ptr_r, rd_ptr_next_s;
    logic [FCNT_W-1:0] fifo_cnt_r, fifo_cnt_next_s;
    logic              pop_s;
    logic              full_s;
    logic              push_ok_s;
    logic              drop_s;
    logic [3:0]        head_next_s;
    logic              key_valid_r;
    logic [3:0]        key_code_r;
    logic              overflow_r;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_FRAMES + 32'sd1);
    localparam logic [REP_W-1:0] REP_ZERO   = REP_W'(32'd0);
    localparam logic [REP_W-1:0] REP_ONE    = REP_W'(32'd1);
    localparam logic [REP_W-1:0] REP_TARGET = REP_W'(REPEAT_FRAMES);
    logic [REP_W-1:0]  rep_cnt_r, rep_cnt_next_s;
`endif

    assign sample_s    = (div_r == DIV_LAST);
    assign frame_end_s = sample_s & row_r[3];

    // Row divider and one-hot row rotation; the row advances on each sample
    always_ff @(posedge clk) begin
        if (!init_n) begin
            div_r <= DIV_ZERO;
            row_r <= 4'b0001;
        end else if (sample_s) begin
            div_r <= DIV_ZERO;
            row_r <= {row_r[2:0], row_r[3]};
        end else begin
            div_r <= div_r + DIV_ONE;
        end
    end

    // Convert the one-hot row strobe into a row index
    always_comb begin
        row_idx_s = 2'd0;
        case (row_r)
            4'b0001: row_idx_s = 2'd0;
            4'b0010: row_idx_s = 2'd1;
            4'b0100: row_idx_s = 2'd2;
            4'b1000: row_idx_s = 2'd3;
            default: row_idx_s = 2'd0;
        endcase
    end

    // Classify the current row sample: no hit, single column, or several columns
    always_comb begin
        row_hit_s   = |col;
        row_multi_s = (col[0] & col[1]) | (col[0] & col[2]) | (col[1] & col[2]);
        col_idx_s   = 2'd0;
        case (col)
            3'b001:  col_idx_s = 2'd0;
            3'b010:  col_idx_s = 2'd1;
            3'b100:  col_idx_s = 2'd2;
            default: col_idx_s = 2'd0;
        endcase
        row_code_s = key_map(row_idx_s, col_idx_s);
    end

    // Fold this row sample into the frame seen so far; hits in two rows are MULTI
    always_comb begin
        merged_hit_s   = acc_hit_r | row_hit_s;
        merged_multi_s = acc_multi_r | row_multi_s | (acc_hit_r & row_hit_s);
        if (row_hit_s) begin
            merged_code_s = row_code_s;
        end else begin
            merged_code_s = acc_code_r;
        end
        res_none_s = ~merged_hit_s;
        res_key_s  = merged_hit_s & ~merged_multi_s;
    end

    // Frame accumulator, cleared at every frame end
    always_ff @(posedge clk) begin
        if (!init_n) begin
            acc_hit_r   <= 1'b0;
            acc_multi_r <= 1'b0;
            acc_code_r  <= 4'd0;
        end else if (frame_end_s) begin
            acc_hit_r   <= 1'b0;
            acc_multi_r <= 1'b0;
            acc_code_r  <= 4'd0;
        end else if (sample_s) begin
            acc_hit_r   <= merged_hit_s;
            acc_multi_r <= merged_multi_s;
            acc_code_r  <= merged_code_s;
        end
    end

    // Debounce FSM: acts only on completed frames; MULTI blocks a press and holds a release
    always_comb begin
        state_next_s     = state_r;
        cnt_next_s       = cnt_r;
        cand_next_s      = cand_r;
        push_next_s      = 1'b0;
        push_code_next_s = push_code_r;
`ifdef KEYPAD_AUTOREPEAT_EN
        if (state_r == ST_HELD) begin
            rep_cnt_next_s = rep_cnt_r;
        end else begin
            rep_cnt_next_s = REP_ZERO;
        end
`endif
        if (frame_end_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (res_key_s) begin
                        cand_next_s = merged_code_s;
                        if (CNT_ONE >= DEB_TARGET) begin
                            push_next_s      = 1'b1;
                            push_code_next_s = merged_code_s;
                            state_next_s     = ST_HELD;
                            cnt_next_s       = CNT_ZERO;
                        end else begin
                            state_next_s = ST_DEB_PRESS;
                            cnt_next_s   = CNT_ONE;
                        end
                    end else begin
                        cnt_next_s = CNT_ZERO;
                    end
                end
                ST_DEB_PRESS: begin
                    if (res_key_s && (merged_code_s == cand_r)) begin
                        if ((cnt_r + CNT_ONE) >= DEB_TARGET) begin
                            push_next_s      = 1'b1;
                            push_code_next_s = cand_r;
                            state_next_s     = ST_HELD;
                            cnt_next_s       = CNT_ZERO;
                        end else begin
                            cnt_next_s = cnt_r + CNT_ONE;
                        end
                    end else begin
                        state_next_s = ST_IDLE;
                        cnt_next_s   = CNT_ZERO;
                    end
                end
                ST_HELD: begin
                    if (res_none_s) begin
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_cnt_next_s = REP_ZERO;
`endif
                        if (CNT_ONE >= DEB_TARGET) begin
                            state_next_s = ST_IDLE;
                            cnt_next_s   = CNT_ZERO;
                        end else begin
                            state_next_s = ST_DEB_RELEASE;
                            cnt_next_s   = CNT_ONE;
                        end
                    end else begin
                        cnt_next_s = CNT_ZERO;
`ifdef KEYPAD_AUTOREPEAT_EN
                        if ((rep_cnt_r + REP_ONE) >= REP_TARGET) begin
                            rep_cnt_next_s = REP_ZERO;
                            if (res_key_s && (merged_code_s == cand_r)) begin
                                push_next_s      = 1'b1;
                                push_code_next_s = cand_r;
                            end else begin
                                push_next_s = 1'b0;
                            end
                        end else begin
                            rep_cnt_next_s = rep_cnt_r + REP_ONE;
                        end
`endif
                    end
                end
                ST_DEB_RELEASE: begin
                    if (res_none_s) begin
                        if ((cnt_r + CNT_ONE) >= DEB_TARGET) begin
                            state_next_s = ST_IDLE;
                            cnt_next_s   = CNT_ZERO;
                        end else begin
                            cnt_next_s = cnt_r + CNT_ONE;
                        end
                    end else begin
                        state_next_s = ST_HELD;
                        cnt_next_s   = CNT_ZERO;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = CNT_ZERO;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // FSM state, debounce count, candidate key and one-cycle push request
    always_ff @(posedge clk) begin
        if (!init_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            cand_r      <= 4'd0;
            push_req_r  <= 1'b0;
            push_code_r <= 4'd0;
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            cand_r      <= cand_next_s;
            push_req_r  <= push_next_s;
            push_code_r <= push_code_next_s;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    // Frames spent in HELD since entry, restarted after each repeat
    always_ff @(posedge clk) begin
        if (!init_n) begin
            rep_cnt_r <= REP_ZERO;
        end else begin
            rep_cnt_r <= rep_cnt_next_s;
        end
    end
`endif

    assign pop_s     = key_valid_r & key_ready;
    assign full_s    = (fifo_cnt_r == FIFO_FULL);
    assign push_ok_s = push_req_r & (~full_s | pop_s);
    assign drop_s    = push_req_r & full_s & ~pop_s;

    // FIFO pointer/occupancy update and the head value seen after this edge
    always_comb begin
        if (push_ok_s) begin
            wr_ptr_next_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
        case ({push_ok_s, pop_s})
            2'b10:   fifo_cnt_next_s = fifo_cnt_r + FCNT_ONE;
            2'b01:   fifo_cnt_next_s = fifo_cnt_r - FCNT_ONE;
            default: fifo_cnt_next_s = fifo_cnt_r;
        endcase
        if (fifo_cnt_next_s == FCNT_ZERO) begin
            head_next_s = 4'd0;
        end else if (push_ok_s && (wr_ptr_r == rd_ptr_next_s)) begin
            head_next_s = push_code_r;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (!init_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 4'd0;
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_code_r;
        end
    end

    // FIFO pointers, registered head/valid outputs and sticky overflow flag
    always_ff @(posedge clk) begin
        if (!init_n) begin
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            fifo_cnt_r  <= FCNT_ZERO;
            key_valid_r <= 1'b0;
            key_code_r  <= 4'd0;
            overflow_r  <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_ptr_next_s;
            rd_ptr_r    <= rd_ptr_next_s;
            fifo_cnt_r  <= fifo_cnt_next_s;
            key_valid_r <= (fifo_cnt_next_s != FCNT_ZERO);
            key_code_r  <= head_next_s;
            overflow_r  <= overflow_r | drop_s;
        end
    end

    assign row       = row_r;
    assign key_code  = key_code_r;
    assign key_valid = key_valid_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with SCAN_DIV=4, DEBOUNCE_SCANS=2,
// FIFO_DEPTH=4: one frame is 16 clocks, frame ends fall on clk 16, 32, ...
// counted from the first posedge after init_n is released.
module tb_keypad_scan_ctrl;

    logic       clk = 1'b0;
    logic       init_n;
    logic [3:0] row;
    logic [2:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       overflow;

    logic [2:0] pressed [4];
    int checks = 0;
    int errors = 0;

    keypad_scan_ctrl #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (2),
        .FIFO_DEPTH     (4),
        .REPEAT_FRAMES  (3)
    ) dut (
        .clk       (clk),
        .init_n    (init_n),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key connects its row strobe to its column line
    always_comb begin
        col = 3'b000;
        for (int r = 0; r < 4; r++) begin
            if (row[r]) col = col | pressed[r];
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic release_all();
        for (int r = 0; r < 4; r++) pressed[r] = 3'b000;
    endtask

    task automatic apply_reset();
        init_n = 1'b0;
        wait_clk(3);
        init_n = 1'b1;
    endtask

    task automatic press(input int r, input int c, input int frames_dn, input int frames_up);
        pressed[r][c] = 1'b1;
        wait_clk(16 * frames_dn);
        pressed[r][c] = 1'b0;
        wait_clk(16 * frames_up);
    endtask

    task automatic test_reset();
        init_n = 1'b0;
        wait_clk(3);
        checks++; if (row !== 4'b0001) begin errors++; $display("FAIL reset_row: got %b want %b", row, 4'b0001); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", key_valid); end
        checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", key_code); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        init_n = 1'b1;
        wait_clk(3);
        checks++; if (row !== 4'b0001) begin errors++; $display("FAIL row_clk3: got %b want %b", row, 4'b0001); end
        wait_clk(1);
        checks++; if (row !== 4'b0010) begin errors++; $display("FAIL row_clk4: got %b want %b", row, 4'b0010); end
        wait_clk(4);
        checks++; if (row !== 4'b0100) begin errors++; $display("FAIL row_clk8: got %b want %b", row, 4'b0100); end
        wait_clk(8);
        checks++; if (row !== 4'b0001) begin errors++; $display("FAIL row_clk16: got %b want %b", row, 4'b0001); end
    endtask

    task automatic test_single_press();
        release_all();
        key_ready = 1'b0;
        apply_reset();
        pressed[1][1] = 1'b1;
        wait_clk(32);
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL press5_early: valid %b want 0 at clk32", key_valid); end
        wait_clk(1);
        checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL press5_valid: valid %b want 1 at clk33", key_valid); end
        checks++; if (key_code !== 4'd5) begin errors++; $display("FAIL press5_code: got %0d want 5", key_code); end
        key_ready = 1'b1;
        wait_clk(1);
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL press5_pop: valid %b want 0", key_valid); end
        wait_clk(64);
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL press5_single: valid %b want 0 while held", key_valid); end
        release_all();
        key_ready = 1'b0;
        wait_clk(32);
    endtask

    task automatic test_rejects();
        release_all();
        key_ready = 1'b0;
        apply_reset();
        press(3, 2, 1, 3);
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL short_hash: valid %b want 0", key_valid); end
        pressed[2] = 3'b011;
        wait_clk(48);
        release_all();
        wait_clk(32);
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL multi_78: valid %b want 0", key_valid); end
        pressed[0] = 3'b001;
        pressed[2] = 3'b100;
        wait_clk(48);
        release_all();
        wait_clk(32);
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL multi_19: valid %b want 0", key_valid); end
        press(3, 1, 2, 2);
        checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL after_reject_valid: valid %b want 1", key_valid); end
        checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL after_reject_code: got %0d want 0", key_code); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rejects_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_overflow();
        logic [3:0] exp_codes [4];
        exp_codes = '{4'd1, 4'd2, 4'd3, 4'd4};
        release_all();
        key_ready = 1'b0;
        apply_reset();
        press(0, 0, 2, 2);
        press(0, 1, 2, 2);
        press(0, 2, 2, 2);
        press(1, 0, 2, 2);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_no_overflow: got %b want 0", overflow); end
        press(1, 2, 2, 2);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b want 1", overflow); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (key_valid !== 1'b1 || key_code !== exp_codes[i]) begin
                errors++; $display("FAIL ovf_pop%0d: valid %b code %0d want valid 1 code %0d", i, key_valid, key_code, exp_codes[i]);
            end
            key_ready = 1'b1;
            wait_clk(1);
            key_ready = 1'b0;
        end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained: valid %b want 0", key_valid); end
        wait_clk(20);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky: got %b want 1", overflow); end
        apply_reset();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_cleared: got %b want 0", overflow); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_codes [4];
        exp_codes = '{4'd2, 4'd3, 4'd4, 4'd6};
        release_all();
        key_ready = 1'b0;
        apply_reset();
        press(0, 0, 2, 2);
        press(0, 1, 2, 2);
        press(0, 2, 2, 2);
        press(1, 0, 2, 2);
        pressed[1][2] = 1'b1;
        wait_clk(32);
        key_ready = 1'b1;
        wait_clk(1);
        key_ready = 1'b0;
        pressed[1][2] = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %b want 0", overflow); end
        wait_clk(47);
        for (int i = 0; i < 4; i++) begin
            checks++; if (key_valid !== 1'b1 || key_code !== exp_codes[i]) begin
                errors++; $display("FAIL b2b_pop%0d: valid %b code %0d want valid 1 code %0d", i, key_valid, key_code, exp_codes[i]);
            end
            key_ready = 1'b1;
            wait_clk(1);
            key_ready = 1'b0;
        end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: valid %b want 0", key_valid); end
    endtask

    task automatic test_reset_mid_debounce();
        release_all();
        key_ready = 1'b1;
        apply_reset();
        pressed[2][2] = 1'b1;
        wait_clk(21);
        init_n = 1'b0;
        wait_clk(3);
        checks++; if (row !== 4'b0001) begin errors++; $display("FAIL mid_reset_row: got %b want %b", row, 4'b0001); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b want 0", key_valid); end
        init_n = 1'b1;
        wait_clk(32);
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_early: valid %b want 0 at clk32", key_valid); end
        wait_clk(1);
        checks++; if (key_valid !== 1'b1 || key_code !== 4'd9) begin
            errors++; $display("FAIL mid_reset_code: valid %b code %0d want valid 1 code 9", key_valid, key_code);
        end
        wait_clk(1);
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_pop: valid %b want 0", key_valid); end
        release_all();
        key_ready = 1'b0;
        wait_clk(32);
    endtask

    initial begin
        init_n    = 1'b0;
        key_ready = 1'b0;
        release_all();
        test_reset();
        test_single_press();
        test_rejects();
        test_overflow();
        test_back_to_back();
        test_reset_mid_debounce();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
